// File: rtl/mac_stream_seq.sv
`default_nettype none
// ============================================================================
// mac_stream_seq : fetches a run of SRAM words into a FWFT FIFO and streams
//                  them into the MAC over valid/ready, then latches the result.
// Optional macro : STEP_SEQ_EN (each step pulse grants one SRAM read in RUN)
// Revision       : 1.0
// ============================================================================
module mac_stream_seq #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MAC_LAT    = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          step_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [ADDR_W:0]               len_i,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_rd_o,
  input  logic [DATA_W-1:0]             mem_rdata_i,
  output logic                          mac_clear_o,
  output logic                          mac_valid_o,
  output logic [DATA_W-1:0]             mac_data_o,
  input  logic                          mac_ready_i,
  input  logic [DATA_W-1:0]             mac_result_i,
  output logic [DATA_W-1:0]             result_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [2:0]                    state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam int FL_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(MAC_LAT - 1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   req_q, req_d;
  logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
  logic               inflight_q, inflight_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic               mac_valid;
  logic               pop;
  logic               push;
  logic               room;
  logic               fetch_ok;
  logic               mem_rd;

  assign mac_valid = (state_q == S_RUN) && (level_q != '0);
  assign pop       = mac_valid && mac_ready_i;
  // Read data lands exactly one cycle after the strobe, so the in-flight flag doubles as push.
  assign push      = inflight_q;
  assign room      = (level_q + LVL_W'(inflight_q)) < DEPTH_L;
  assign fetch_ok  = (state_q == S_RUN) && (req_q < len_q) && room;

`ifdef STEP_SEQ_EN
  logic grant_q, grant_d;

  // At most one outstanding grant; it is consumed by the read it enables.
  assign grant_d = (state_q == S_RUN) && ((grant_q && !mem_rd) || step_i);
  assign mem_rd  = fetch_ok && grant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
    end
  end
`else
  logic unused_step;

  assign unused_step = step_i;
  assign mem_rd      = fetch_ok;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    req_d       = req_q + CNT_W'(mem_rd);
    pop_cnt_d   = pop_cnt_q + CNT_W'(pop);
    inflight_d  = mem_rd;
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    flush_d     = flush_q;
    result_d    = result_q;
    done_d      = 1'b0;
    mac_clear_o = 1'b0;

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d    = base_addr_i;
          len_d     = len_i;
          req_d     = '0;
          pop_cnt_d = '0;
          state_d   = (len_i == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clear_o = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        flush_d = '0;
        if (pop && ((pop_cnt_q + CNT_W'(1)) == len_q)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_q == FL_LAST) begin
          state_d = S_DONE;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      S_DONE: begin
        // Result and done register together so the pulse marks the update.
        result_d = mac_result_i;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      req_q      <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      flush_q    <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      req_q      <= req_d;
      pop_cnt_q  <= pop_cnt_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      flush_q    <= flush_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_rdata_i;
    end
  end

  assign mem_addr_o   = base_q + req_q[ADDR_W-1:0];
  assign mem_rd_o     = mem_rd;
  assign mac_valid_o  = mac_valid;
  assign mac_data_o   = mac_valid ? fifo_mem[rd_ptr_q] : '0;
  assign result_o     = result_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign fifo_level_o = level_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_stream_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mac_stream_seq : scoreboard bench with SRAM and adder-MAC models.
// Revision          : 1.0
// ============================================================================
module tb_mac_stream_seq;

  localparam int MAC_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  len = '0;
  logic [3:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        mac_clear;
  logic        mac_valid;
  logic [15:0] mac_data;
  logic        mac_ready = 1'b1;
  logic [15:0] mac_result;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic [3:0]  fifo_level;
  logic [2:0]  state;

  mac_stream_seq #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(8), .MAC_LAT(MAC_LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .step_i(step),
    .base_addr_i(base_addr), .len_i(len), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd),
    .mem_rdata_i(mem_rdata), .mac_clear_o(mac_clear), .mac_valid_o(mac_valid),
    .mac_data_o(mac_data), .mac_ready_i(mac_ready), .mac_result_i(mac_result),
    .result_o(result), .busy_o(busy), .done_o(done), .fifo_level_o(fifo_level),
    .state_o(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency
  logic [15:0] sram [16];
  always @(posedge clk) if (mem_rd) mem_rdata <= sram[mem_addr];

  // MAC model: adder whose output trails the last accepted input by MAC_LAT cycles
  logic [15:0] acc = '0, p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (mac_clear) acc <= '0;
    else if (mac_valid && mac_ready) acc <= acc + mac_data;
    p1 <= acc;
    p2 <= p1;
  end
  assign mac_result = p2;

  // Monitor: records DUT activity; only appends, tasks work from snapshots
  int          rd_cyc_q[$], pop_cyc_q[$], done_cyc_q[$];
  logic [15:0] pop_data_q[$];
  logic [3:0]  addr_q[$];
  int          clr_cnt = 0, rd_full_cnt = 0, hold_bad = 0;
  logic        stall_q = 1'b0;
  logic [15:0] hold_data = '0;

  always @(negedge clk) begin
    if (mem_rd) begin
      rd_cyc_q.push_back(cyc);
      addr_q.push_back(mem_addr);
      if (fifo_level == 4'd8) rd_full_cnt++;
    end
    if (mac_valid && mac_ready) begin
      pop_cyc_q.push_back(cyc);
      pop_data_q.push_back(mac_data);
    end
    if (mac_clear) clr_cnt++;
    if (done) done_cyc_q.push_back(cyc);
    if (stall_q && mac_valid && mac_data !== hold_data) hold_bad++;
    stall_q   = mac_valid && !mac_ready;
    hold_data = mac_data;
  end

  int          total = 0, bad = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  exp_addr_q[$];

  task automatic do_start(input logic [3:0] b, input logic [4:0] l, output int t0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l; t0 = cyc;
    for (int k = 0; k < int'(l); k++) exp_q.push_back(sram[b + 4'(k)]);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int limit, output bit ok);
    int i = 0;
    while (done_cyc_q.size() <= n0 && i < limit) begin
      @(negedge clk); #1;
      i++;
    end
    ok = (done_cyc_q.size() > n0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (mem_addr !== 4'd0)    begin bad++; $display("FAIL reset mem_addr: got %0d want 0", mem_addr); end
    total++; if (mem_rd !== 1'b0)      begin bad++; $display("FAIL reset mem_rd: got %b want 0", mem_rd); end
    total++; if (mac_clear !== 1'b0)   begin bad++; $display("FAIL reset mac_clear: got %b want 0", mac_clear); end
    total++; if (mac_valid !== 1'b0)   begin bad++; $display("FAIL reset mac_valid: got %b want 0", mac_valid); end
    total++; if (mac_data !== 16'd0)   begin bad++; $display("FAIL reset mac_data: got %0h want 0", mac_data); end
    total++; if (result !== 16'd0)     begin bad++; $display("FAIL reset result: got %0d want 0", result); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset done: got %b want 0", done); end
    total++; if (fifo_level !== 4'd0)  begin bad++; $display("FAIL reset fifo_level: got %0d want 0", fifo_level); end
    total++; if (state !== 3'd0)       begin bad++; $display("FAIL reset state: got %0d want 0", state); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_full_run();
    int t0, np, nr, nd, nc, idx;
    bit ok;
    logic [15:0] e;
    np = pop_data_q.size(); nr = rd_cyc_q.size(); nd = done_cyc_q.size(); nc = clr_cnt;
    mac_ready = 1'b1;
    do_start(4'd0, 5'd16, t0);
    wait_done(nd, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL full done_timeout: got none want pulse"); end
    if (ok) begin
      total++; if (done_cyc_q[nd] - t0 !== 24) begin bad++; $display("FAIL full done_cycle: got %0d want 24", done_cyc_q[nd] - t0); end
    end
    total++; if (result !== 16'd136) begin bad++; $display("FAIL full result: got %0d want 136", result); end
    total++; if (state !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL full idle_after_done: got state %0d busy %b want 0 0", state, busy); end
    total++; if (rd_cyc_q.size() - nr !== 16) begin bad++; $display("FAIL full rd_count: got %0d want 16", rd_cyc_q.size() - nr); end
    total++; if (clr_cnt - nc !== 1) begin bad++; $display("FAIL full clear_count: got %0d want 1", clr_cnt - nc); end
    if (rd_cyc_q.size() > nr) begin
      total++; if (rd_cyc_q[nr] - t0 !== 2) begin bad++; $display("FAIL full first_rd: got %0d want 2", rd_cyc_q[nr] - t0); end
    end
    if (pop_cyc_q.size() >= np + 16) begin
      total++; if (pop_cyc_q[np] - t0 !== 4) begin bad++; $display("FAIL full first_valid: got %0d want 4", pop_cyc_q[np] - t0); end
      total++; if (pop_cyc_q[np + 15] - t0 !== 19) begin bad++; $display("FAIL full last_pop: got %0d want 19", pop_cyc_q[np + 15] - t0); end
    end
    idx = np;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (idx >= pop_data_q.size() || pop_data_q[idx] !== e) begin
        bad++; $display("FAIL full word%0d: got %0d want %0d", idx - np, (idx < pop_data_q.size()) ? pop_data_q[idx] : 16'hxxxx, e);
      end
      idx++;
    end
  endtask

  task automatic test_wrap();
    int t0, t1, np, na, nd, idx;
    bit ok;
    logic [15:0] e;
    logic [3:0] ea;
    np = pop_data_q.size(); na = addr_q.size(); nd = done_cyc_q.size();
    exp_addr_q.push_back(4'd14); exp_addr_q.push_back(4'd15);
    exp_addr_q.push_back(4'd0);  exp_addr_q.push_back(4'd1);
    do_start(4'd14, 5'd4, t0);
    repeat (2) @(posedge clk);
    do_start(4'd0, 5'd0, t1);
    void'(exp_q.size());
    wait_done(nd, 100, ok);
    repeat (6) @(negedge clk);
    #1;
    total++; if (done_cyc_q.size() - nd !== 1) begin bad++; $display("FAIL wrap done_count: got %0d want 1", done_cyc_q.size() - nd); end
    total++; if (result !== 16'd34) begin bad++; $display("FAIL wrap result: got %0d want 34", result); end
    idx = na;
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      total++;
      if (idx >= addr_q.size() || addr_q[idx] !== ea) begin
        bad++; $display("FAIL wrap addr%0d: got %0d want %0d", idx - na, (idx < addr_q.size()) ? addr_q[idx] : 4'hx, ea);
      end
      idx++;
    end
    idx = np;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (idx >= pop_data_q.size() || pop_data_q[idx] !== e) begin
        bad++; $display("FAIL wrap word%0d: got %0d want %0d", idx - np, (idx < pop_data_q.size()) ? pop_data_q[idx] : 16'hxxxx, e);
      end
      idx++;
    end
  endtask

  task automatic test_backpressure();
    int t0, np, nr, nd, nf, nh, idx;
    bit ok;
    logic [15:0] e;
    np = pop_data_q.size(); nr = rd_cyc_q.size(); nd = done_cyc_q.size();
    nf = rd_full_cnt; nh = hold_bad;
    mac_ready = 1'b0;
    do_start(4'd0, 5'd16, t0);
    repeat (20) @(negedge clk);
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL bp level_full: got %0d want 8", fifo_level); end
    total++; if (rd_cyc_q.size() - nr !== 8) begin bad++; $display("FAIL bp rd_while_stalled: got %0d want 8", rd_cyc_q.size() - nr); end
    @(posedge clk); #1 mac_ready = 1'b1;
    wait_done(nd, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp done_timeout: got none want pulse"); end
    total++; if (result !== 16'd136) begin bad++; $display("FAIL bp result: got %0d want 136", result); end
    total++; if (rd_full_cnt - nf !== 0) begin bad++; $display("FAIL bp rd_when_full: got %0d want 0", rd_full_cnt - nf); end
    total++; if (hold_bad - nh !== 0) begin bad++; $display("FAIL bp data_hold: got %0d changes want 0", hold_bad - nh); end
    idx = np;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (idx >= pop_data_q.size() || pop_data_q[idx] !== e) begin
        bad++; $display("FAIL bp word%0d: got %0d want %0d", idx - np, (idx < pop_data_q.size()) ? pop_data_q[idx] : 16'hxxxx, e);
      end
      idx++;
    end
  endtask

  task automatic test_len0();
    int t0, nr, nd, nc;
    bit ok;
    nr = rd_cyc_q.size(); nd = done_cyc_q.size(); nc = clr_cnt;
    do_start(4'd3, 5'd0, t0);
    total++; if (state !== 3'd4 || busy !== 1'b1) begin bad++; $display("FAIL len0 state_done: got state %0d busy %b want 4 1", state, busy); end
    wait_done(nd, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL len0 done_timeout: got none want pulse"); end
    if (ok) begin
      total++; if (done_cyc_q[nd] - t0 !== 2) begin bad++; $display("FAIL len0 done_cycle: got %0d want 2", done_cyc_q[nd] - t0); end
    end
    total++; if (rd_cyc_q.size() - nr !== 0) begin bad++; $display("FAIL len0 rd_count: got %0d want 0", rd_cyc_q.size() - nr); end
    total++; if (clr_cnt - nc !== 0) begin bad++; $display("FAIL len0 clear_count: got %0d want 0", clr_cnt - nc); end
    // The MAC model still holds the previous run's sum.
    total++; if (result !== 16'd136) begin bad++; $display("FAIL len0 result: got %0d want 136", result); end
  endtask

  task automatic test_midrun_reset();
    int t0, np, nd, idx, leak;
    bit ok;
    logic [15:0] e;
    do_start(4'd0, 5'd16, t0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_addr, mem_rd, mac_clear, mac_valid, mac_data, result, busy, done, fifo_level, state} !== '0) begin
      bad++; $display("FAIL rst outputs: got addr%0d rd%b clr%b v%b d%0d res%0d busy%b done%b lvl%0d st%0d want all 0",
                      mem_addr, mem_rd, mac_clear, mac_valid, mac_data, result, busy, done, fifo_level, state);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    leak = 0;
    repeat (3) begin
      @(negedge clk);
      if (fifo_level !== 4'd0 || mac_valid !== 1'b0) leak++;
    end
    total++; if (leak !== 0) begin bad++; $display("FAIL rst inflight_dropped: got %0d nonempty cycles want 0", leak); end
    np = pop_data_q.size(); nd = done_cyc_q.size();
    do_start(4'd0, 5'd2, t0);
    wait_done(nd, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst done_timeout: got none want pulse"); end
    total++; if (result !== 16'd3) begin bad++; $display("FAIL rst result: got %0d want 3", result); end
    idx = np;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (idx >= pop_data_q.size() || pop_data_q[idx] !== e) begin
        bad++; $display("FAIL rst word%0d: got %0d want %0d", idx - np, (idx < pop_data_q.size()) ? pop_data_q[idx] : 16'hxxxx, e);
      end
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    int t0, np, nd, idx;
    bit ok;
    logic [15:0] e;
    np = pop_data_q.size(); nd = done_cyc_q.size();
    do_start(4'd4, 5'd3, t0);
    wait_done(nd, 50, ok);
    total++; if (!ok || result !== 16'd18) begin bad++; $display("FAIL b2b result1: got %0d want 18", result); end
    do_start(4'd8, 5'd2, t0);
    wait_done(nd + 1, 50, ok);
    total++; if (!ok || result !== 16'd19) begin bad++; $display("FAIL b2b result2: got %0d want 19", result); end
    idx = np;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (idx >= pop_data_q.size() || pop_data_q[idx] !== e) begin
        bad++; $display("FAIL b2b word%0d: got %0d want %0d", idx - np, (idx < pop_data_q.size()) ? pop_data_q[idx] : 16'hxxxx, e);
      end
      idx++;
    end
  endtask

  task automatic test_step();
    int t0, nr, nd, np;
    bit ok;
    nr = rd_cyc_q.size();
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rd_cyc_q.size() - nr !== 0 || state !== 3'd0) begin bad++; $display("FAIL step idle_ignored: got rd %0d state %0d want 0 0", rd_cyc_q.size() - nr, state); end
    nr = rd_cyc_q.size(); nd = done_cyc_q.size(); np = pop_cyc_q.size();
    do_start(4'd0, 5'd3, t0);
    exp_q.delete();
`ifdef STEP_SEQ_EN
    repeat (10) @(negedge clk);
    total++; if (rd_cyc_q.size() - nr !== 0) begin bad++; $display("FAIL step no_grant: got %0d reads want 0", rd_cyc_q.size() - nr); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      total++; if (rd_cyc_q.size() - nr !== i + 1) begin bad++; $display("FAIL step grant%0d: got %0d reads want %0d", i, rd_cyc_q.size() - nr, i + 1); end
    end
    wait_done(nd, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL step done_timeout: got none want pulse"); end
    if (ok && pop_cyc_q.size() >= np + 3) begin
      total++; if (done_cyc_q[nd] - pop_cyc_q[np + 2] !== MAC_LAT + 2) begin bad++; $display("FAIL step done_delay: got %0d want %0d", done_cyc_q[nd] - pop_cyc_q[np + 2], MAC_LAT + 2); end
    end
`else
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    wait_done(nd, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL step done_timeout: got none want pulse"); end
    if (ok) begin
      total++; if (done_cyc_q[nd] - t0 !== 3 + 3 + MAC_LAT + 2) begin bad++; $display("FAIL step done_cycle: got %0d want %0d", done_cyc_q[nd] - t0, 3 + 3 + MAC_LAT + 2); end
    end
    total++; if (rd_cyc_q.size() - nr !== 3) begin bad++; $display("FAIL step rd_count: got %0d want 3", rd_cyc_q.size() - nr); end
`endif
    total++; if (result !== 16'd6) begin bad++; $display("FAIL step result: got %0d want 6", result); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 16'(i + 1);
    test_reset();
    test_full_run();
    test_wrap();
    test_backpressure();
    test_len0();
    test_midrun_reset();
    test_back_to_back();
    test_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
